// File: rtl/jk_pkg.sv
// Shared types for the JK command driver: op encoding, FSM states and the queued command word.
package jk_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_HOLD   = 2'b00;
  localparam op_t OP_RESET  = 2'b01;
  localparam op_t OP_SET    = 2'b10;
  localparam op_t OP_TOGGLE = 2'b11;

  typedef enum logic {IDLE, DRIVE} state_t;

  localparam int CMD_CNT_W = 4;

  typedef struct packed {
    op_t                  op;
    logic [CMD_CNT_W-1:0] cnt;
  } cmd_t;

  // Next flop state for a given {j,k}; used by the optional checker.
  function automatic logic jk_next(input logic q, input op_t op);
    case (op)
      OP_RESET:  jk_next = 1'b0;
      OP_SET:    jk_next = 1'b1;
      OP_TOGGLE: jk_next = ~q;
      default:   jk_next = q;
    endcase
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous FIFO for the command queue; an extra pointer bit separates full from empty.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/jk_cmd_driver.sv
// Queues {j,k} commands and drives a JK flop for cmd_cnt+1 cycles each.
// Optional truth-table checker on q_in enabled by defining JK_CHECK_EN.
module jk_cmd_driver
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = CMD_CNT_W  // must equal the cnt width of cmd_t
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             j,
  output logic             k,
  input  logic             q_in,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CMD_W = $bits(cmd_t);

  state_t           state;
  logic [CNT_W-1:0] rem;
  logic             full;
  logic             empty;
  logic             push;
  logic             load;
  logic [CMD_W-1:0] wr_word;
  logic [CMD_W-1:0] rd_word;
  cmd_t             head;

  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign wr_word   = {cmd_op, cmd_cnt};
  assign head      = cmd_t'(rd_word);
  assign done      = (state == DRIVE) && (rem == '0);
  assign busy      = (state == DRIVE) || !empty;
  // A pop happens from IDLE or on the last drive cycle, giving gap-free chaining.
  assign load      = !rst && !empty && ((state == IDLE) || done);

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_word),
    .pop   (load),
    .rdata (rd_word),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      j      <= 1'b0;
      k      <= 1'b0;
      rem    <= '0;
    end else if (load) begin
      {j, k} <= head.op;
      rem    <= head.cnt;
      state  <= DRIVE;
    end else if (state == DRIVE) begin
      if (rem != '0) begin
        rem    <= rem - CNT_W'(1);
      end else begin
        {j, k} <= OP_HOLD;
        state  <= IDLE;
      end
    end
  end

`ifdef JK_CHECK_EN
  logic exp;
  logic exp_valid;

  // The flop has no reset, so only SET/RESET make exp trustworthy.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp       <= 1'b0;
      exp_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      exp <= jk_next(exp, {j, k});
      if (j != k)
        exp_valid <= 1'b1;
      if (exp_valid && (q_in != exp))
        err <= 1'b1;
    end
  end
`else
  logic unused_q_in;
  assign unused_q_in = q_in;
  assign err         = 1'b0;
`endif

endmodule
